// File: rtl/vga_text_writer_pkg.sv
// Shared definitions for the character-RAM write front end: control-character
// codes and the sequencer state encoding. The HEX_LO state only exists when
// HEX_WRITE_EN is defined (it is left undefined by default).
package vga_text_writer_pkg;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

`ifdef HEX_WRITE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_HEX_LO = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/vga_text_writer_nib2ascii.sv
// Combinational nibble to ASCII hex digit ('0'-'9', 'A'-'F' uppercase).
// Shared with the display side's hex translation.
module nib2ascii (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // Digits map onto '0'.., letters onto 'A'.. (0x37 + 10 = 0x41)
  always_comb begin
    if (nib < 4'd10) begin
      ascii = 8'h30 + {4'h0, nib};
    end else begin
      ascii = 8'h37 + {4'h0, nib};
    end
  end

endmodule

// File: rtl/vga_text_writer.sv
// Write-side front end of the text character RAM. Accepts a byte stream over
// valid/ready, keeps a text cursor, writes printable bytes at the cursor and
// decodes CR, LF, BS and FF (clear screen).
// Optional build macro: HEX_WRITE_EN adds the hex port, the HEX_LO state and
// writes bytes flagged with hex=1 as two uppercase hex digits.
module vga_text_writer
  import vga_text_writer_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter int         ROWS       = 4,
  parameter logic [7:0] OFFSET     = 8'h00,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
`ifdef HEX_WRITE_EN
  input  logic       hex,
`endif
  output logic [7:0] waddr,
  output logic [7:0] wdata,
  output logic       we,
  output logic [7:0] cur_x,
  output logic [7:0] cur_y
);

  // 8-bit arithmetic throughout: addresses wrap modulo 256 by construction
  localparam logic [7:0] COLS_B = 8'(COLS);
  localparam logic [7:0] X_LAST = 8'(COLS - 1);
  localparam logic [7:0] Y_LAST = 8'(ROWS - 1);
  localparam logic [8:0] CELLS  = 9'(COLS * ROWS);

  state_t     state_r, state_s;
  logic [7:0] cur_x_r, cur_x_s;
  logic [7:0] cur_y_r, cur_y_s;
  logic       we_r, we_s;
  logic [7:0] waddr_r, waddr_s;
  logic [7:0] wdata_r, wdata_s;
  // Number of clear writes already issued
  logic [8:0] clr_cnt_r, clr_cnt_s;

  logic       accept_s;
  logic [7:0] cell_addr_s;
  logic [7:0] adv_x_s, adv_y_s, next_line_s;

`ifdef HEX_WRITE_EN
  logic [3:0] hex_lo_r, hex_lo_s;
  logic [7:0] hi_ascii_s, lo_ascii_s;

  nib2ascii u_nib_hi (.nib(din[7:4]), .ascii(hi_ascii_s));
  nib2ascii u_nib_lo (.nib(hex_lo_r), .ascii(lo_ascii_s));
`endif

  assign din_ready   = (state_r == ST_IDLE) && !rst;
  assign accept_s    = din_valid && din_ready;
  assign cell_addr_s = OFFSET + cur_y_r * COLS_B + cur_x_r;

  // Cursor advance by one cell, wrapping at the end of a line and of the window
  always_comb begin
    if (cur_y_r == Y_LAST) begin
      next_line_s = 8'd0;
    end else begin
      next_line_s = cur_y_r + 8'd1;
    end
    if (cur_x_r == X_LAST) begin
      adv_x_s = 8'd0;
      adv_y_s = next_line_s;
    end else begin
      adv_x_s = cur_x_r + 8'd1;
      adv_y_s = cur_y_r;
    end
  end

  // Next-state and registered-output values for the write sequencer
  always_comb begin
    state_s   = state_r;
    cur_x_s   = cur_x_r;
    cur_y_s   = cur_y_r;
    we_s      = 1'b0;
    waddr_s   = waddr_r;
    wdata_s   = wdata_r;
    clr_cnt_s = clr_cnt_r;
`ifdef HEX_WRITE_EN
    hex_lo_s  = hex_lo_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef HEX_WRITE_EN
          if (hex) begin
            // High digit now, low digit from HEX_LO on the next cycle
            we_s     = 1'b1;
            waddr_s  = cell_addr_s;
            wdata_s  = hi_ascii_s;
            cur_x_s  = adv_x_s;
            cur_y_s  = adv_y_s;
            hex_lo_s = din[3:0];
            state_s  = ST_HEX_LO;
          end else begin
`endif
          case (din)
            ASCII_CR: begin
              cur_x_s = 8'd0;
            end
            ASCII_LF: begin
              cur_x_s = 8'd0;
              cur_y_s = next_line_s;
            end
            ASCII_BS: begin
              if (cur_x_r != 8'd0) begin
                cur_x_s = cur_x_r - 8'd1;
              end else begin
                cur_x_s = cur_x_r;
              end
            end
            ASCII_FF: begin
              // First clear write goes out together with entering CLEAR
              state_s   = ST_CLEAR;
              we_s      = 1'b1;
              waddr_s   = OFFSET;
              wdata_s   = CLEAR_CHAR;
              clr_cnt_s = 9'd1;
            end
            default: begin
              we_s    = 1'b1;
              waddr_s = cell_addr_s;
              wdata_s = din;
              cur_x_s = adv_x_s;
              cur_y_s = adv_y_s;
            end
          endcase
`ifdef HEX_WRITE_EN
          end
`endif
        end else begin
          we_s = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == CELLS) begin
          state_s = ST_IDLE;
          cur_x_s = 8'd0;
          cur_y_s = 8'd0;
        end else begin
          we_s      = 1'b1;
          waddr_s   = OFFSET + clr_cnt_r[7:0];
          wdata_s   = CLEAR_CHAR;
          clr_cnt_s = clr_cnt_r + 9'd1;
        end
      end
`ifdef HEX_WRITE_EN
      ST_HEX_LO: begin
        we_s    = 1'b1;
        waddr_s = cell_addr_s;
        wdata_s = lo_ascii_s;
        cur_x_s = adv_x_s;
        cur_y_s = adv_y_s;
        state_s = ST_IDLE;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any clear or hex sequence
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cur_x_r   <= 8'd0;
      cur_y_r   <= 8'd0;
      we_r      <= 1'b0;
      waddr_r   <= 8'd0;
      wdata_r   <= 8'd0;
      clr_cnt_r <= 9'd0;
`ifdef HEX_WRITE_EN
      hex_lo_r  <= 4'd0;
`endif
    end else begin
      state_r   <= state_s;
      cur_x_r   <= cur_x_s;
      cur_y_r   <= cur_y_s;
      we_r      <= we_s;
      waddr_r   <= waddr_s;
      wdata_r   <= wdata_s;
      clr_cnt_r <= clr_cnt_s;
`ifdef HEX_WRITE_EN
      hex_lo_r  <= hex_lo_s;
`endif
    end
  end

  assign cur_x = cur_x_r;
  assign cur_y = cur_y_r;
  assign we    = we_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer. A reference model tracks the cursor
// as a linear cell index and queues expected RAM writes; a monitor pops and
// compares on every we pulse. Hex cases run when HEX_WRITE_EN is defined.
module tb_vga_text_writer;

  localparam int         COLS   = 16;
  localparam int         ROWS   = 4;
  localparam int         CELLS  = COLS * ROWS;
  localparam logic [7:0] OFFSET = 8'h10;
  localparam logic [7:0] CLR    = 8'h20;

  logic       px_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
`ifdef HEX_WRITE_EN
  logic       hex = 1'b0;
`endif
  logic [7:0] waddr, wdata, cur_x, cur_y;
  logic       we;

  vga_text_writer #(
    .COLS(COLS), .ROWS(ROWS), .OFFSET(OFFSET), .CLEAR_CHAR(CLR)
  ) dut (
    .px_clk(px_clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready),
`ifdef HEX_WRITE_EN
    .hex(hex),
`endif
    .waddr(waddr), .wdata(wdata), .we(we), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    bit         chk;
    int         x;
    int         y;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    pos = 0;          // model cursor as linear cell index y*COLS+x
  string hexdig = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_cursor(input string name);
    check({name, "_x"}, cur_x, pos % COLS);
    check({name, "_y"}, cur_y, pos / COLS);
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_t e;
    e.a = 8'(int'(OFFSET) + pos);
    e.d = d;
    pos = (pos + 1) % CELLS;
    e.chk = 1'b1;
    e.x = pos % COLS;
    e.y = pos / COLS;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit h);
    exp_t e;
    if (h) begin
      model_write(hexdig[b[7:4]]);
      model_write(hexdig[b[3:0]]);
    end else begin
      case (b)
        8'h0D: pos = pos - (pos % COLS);
        8'h0A: pos = (((pos / COLS) + 1) % ROWS) * COLS;
        8'h08: if ((pos % COLS) > 0) pos = pos - 1;
        8'h0C: begin
          for (int k = 0; k < CELLS; k++) begin
            e.a = 8'(int'(OFFSET) + k);
            e.d = CLR;
            e.chk = 1'b0;
            e.x = 0;
            e.y = 0;
            exp_q.push_back(e);
          end
          pos = 0;
        end
        default: model_write(b);
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] b, input bit h);
    int guard = 0;
    din = b;
    din_valid = 1'b1;
`ifdef HEX_WRITE_EN
    hex = h;
`endif
    while (!din_ready && guard < 500) begin
      @(negedge px_clk);
      guard++;
    end
    if (!din_ready) begin
      check("din_ready_timeout", din_ready, 1);
      din_valid = 1'b0;
    end else begin
      model_byte(b, h);
      @(negedge px_clk);
      din_valid = 1'b0;
    end
  endtask

  // Scoreboard monitor: every we pulse must match the oldest expected write
  always @(negedge px_clk) begin : monitor
    exp_t e;
    if (!rst && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: waddr=%0h wdata=%0h, required no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        check("waddr", waddr, e.a);
        check("wdata", wdata, e.d);
        if (e.chk) begin
          check("cur_x_after_write", cur_x, e.x);
          check("cur_y_after_write", cur_y, e.y);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    logic [7:0] rb;

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) begin
      @(negedge px_clk);
      check("rst_we", we, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_cursor", {cur_y, cur_x}, 0);
      check("rst_din_ready", din_ready, 0);
    end
    rst = 1'b0;
    #1;
    check("ready_after_rst", din_ready, 1);
    @(negedge px_clk);

    // Back-to-back printable writes from (0,0)
    send(8'h41, 1'b0);
    check("write_A_cur_x", cur_x, 1);
    send(8'h42, 1'b0);
    check("write_B_cur_x", cur_x, 2);

    // Move to (5,2) then exercise the controls
    send(8'h0A, 1'b0);
    send(8'h0A, 1'b0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
    check("ctrl_start", {cur_y, cur_x}, {8'd2, 8'd5});
    send(8'h08, 1'b0);
    check("bs_cursor", {cur_y, cur_x}, {8'd2, 8'd4});
    send(8'h0D, 1'b0);
    check("cr_cursor", {cur_y, cur_x}, {8'd2, 8'd0});
    send(8'h0A, 1'b0);
    check("lf_cursor", {cur_y, cur_x}, {8'd3, 8'd0});
    send(8'h0A, 1'b0);
    check("lf_wrap_cursor", {cur_y, cur_x}, {8'd0, 8'd0});
    send(8'h08, 1'b0);
    check("bs_at_col0", {cur_y, cur_x}, {8'd0, 8'd0});

    // Wrap: 16 writes from (0,3) end back at (0,0)
    repeat (3) send(8'h0A, 1'b0);
    for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i), 1'b0);
    check("wrap_cursor", {cur_y, cur_x}, 16'd0);

    // Clear screen: ready low for exactly CELLS cycles
    send(8'h33, 1'b0);
    send(8'h0C, 1'b0);
    n = 0;
    while (!din_ready && n < 1000) begin
      n++;
      @(negedge px_clk);
    end
    check("clear_busy_cycles", n, CELLS);
    check("clear_cursor", {cur_y, cur_x}, 16'd0);
    check("clear_all_written", exp_q.size(), 0);

    // Reset at clear cycle 10 abandons the clear
    send(8'h0C, 1'b0);
    repeat (9) @(negedge px_clk);
    #2;
    rst = 1'b1;
    #1;
    check("midclr_rst_we", we, 0);
    check("midclr_rst_waddr", waddr, 0);
    check("midclr_rst_wdata", wdata, 0);
    check("midclr_rst_ready", din_ready, 0);
    exp_q.delete();
    pos = 0;
    repeat (3) @(negedge px_clk);
    rst = 1'b0;
    #1;
    check("midclr_idle_ready", din_ready, 1);
    check("midclr_cursor", {cur_y, cur_x}, 16'd0);
    @(negedge px_clk);

`ifdef HEX_WRITE_EN
    // Hex 0xA7 at (15,0): 'A' then '7', wrap between digits
    for (int i = 0; i < COLS - 1; i++) send(8'h2E, 1'b0);
    send(8'hA7, 1'b1);
    check("hex_lo_ready", din_ready, 0);
    @(negedge px_clk);
    check("hex_ready_back", din_ready, 1);
    check("hex_cursor", {cur_y, cur_x}, {8'd1, 8'd1});
`endif

    // Randomized stream with idle gaps
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      rb = 8'($urandom_range(0, 255));
      if (r < 5) send(8'h0D, 1'b0);
      else if (r < 10) send(8'h0A, 1'b0);
      else if (r < 16) send(8'h08, 1'b0);
      else if (r == 16) send(8'h0C, 1'b0);
`ifdef HEX_WRITE_EN
      else if (r < 35) send(rb, 1'b1);
`endif
      else if (rb == 8'h0C) send(8'h7E, 1'b0);
      else send(rb, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge px_clk);
    end
    repeat (CELLS + 4) @(negedge px_clk);
    check_cursor("random_final");
    check("random_all_written", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
